traffic_intersection_ctrl: RTL and testbench

//  Parametrised N-approach intersection signal controller; successor to the fixed 3-state lamp sequencer.

---
 rtl/traffic_intersection_ctrl_pkg.sv | 27 ++
 rtl/traffic_intersection_ctrl_if.sv | 15 +
 rtl/traffic_intersection_ctrl_tick_prescaler.sv | 17 +
 rtl/traffic_intersection_ctrl.sv | 121 ++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/traffic_intersection_ctrl_pkg.sv
// traffic_pkg: shared state encoding, lamp codes and round-robin helpers for the intersection controller
package traffic_pkg;
  typedef enum logic [1:0] {ST_GREEN = 2'b00, ST_YELLOW = 2'b01, ST_ALLRED = 2'b10, ST_FLASH = 2'b11} state_t;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam int MAX_APPR = 8;
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
  // First pending approach searching from cur+1 over the other approaches only;
  // with none pending the rotation simply advances to cur+1.
  function automatic logic [2:0] next_pending(input logic [7:0] mask, input logic [2:0] cur, input int n);
    logic [2:0] idx;
    logic found;
    next_pending = 3'((int'(cur) + 1) % n);
    found = 1'b0;
    for (int k = 1; k < MAX_APPR; k++) begin
      idx = 3'((int'(cur) + k) % n);
      if (!found && k < n && mask[idx]) begin
        next_pending = idx;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/traffic_intersection_ctrl_if.sv
// traffic_intersection_ctrl_if: board-side bundle of the controller
//   flash/actuated/req : mode switches and per-approach requests into the controller
//   lamp/phase/state   : lamp drives ({R,Y,G} per approach), served approach, controller state
interface traffic_intersection_ctrl_if #(parameter int N_APPR = 2);
  import traffic_pkg::*;
  localparam int PW = N_APPR > 1 ? $clog2(N_APPR) : 1;
  logic flash;
  logic actuated;
  logic [N_APPR-1:0] req;
  logic [3*N_APPR-1:0] lamp;
  logic [PW-1:0] phase;
  state_t state;
  modport master (output flash, actuated, req, input lamp, phase, state);
  modport slave (input flash, actuated, req, output lamp, phase, state);
endinterface

// File: rtl/traffic_intersection_ctrl_tick_prescaler.sv
// tick_prescaler: free-running divider emitting a one-clk tick every TICK_DIV clks
//   clk, rst_n : clock and async active-low reset
//   tick       : timing tick pulse
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV + 1);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: N-approach signal controller with fixed/actuated rotation and flashing yellow
//   clk, rst_n : clock and async active-low reset
//   bus        : flash/actuated/req in; lamp (registered decode), phase, state out
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPR          = 2,
  parameter int TICK_DIV        = 50_000_000,
  parameter int GREEN_TICKS     = 4,
  parameter int MAX_GREEN_TICKS = 12,
  parameter int YELLOW_TICKS    = 1,
  parameter int CLEAR_TICKS     = 1,
  parameter int FLASH_TICKS     = 1,
  parameter int LAMP_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  traffic_intersection_ctrl_if.slave bus
);
  localparam int PW = N_APPR > 1 ? $clog2(N_APPR) : 1;
  localparam int MX = max_of(max_of(GREEN_TICKS, MAX_GREEN_TICKS), max_of(YELLOW_TICKS, max_of(CLEAR_TICKS, FLASH_TICKS)));
  localparam int DW = $clog2(MX) + 1;
  localparam logic [2:0] POL = LAMP_ACTIVE_LOW != 0 ? 3'b111 : 3'b000;
  localparam logic [PW:0] N_LIM = (PW + 1)'(N_APPR);
  state_t state, state_n;
  logic [PW-1:0] phase, phase_n, phase_inc;
  logic [DW-1:0] dwell, dwell_n;
  logic [N_APPR-1:0] latch, latch_n, others;
  logic [3*N_APPR-1:0] lamp_n;
  logic [2:0] rr;
  logic blink, blink_n, first, first_n, tick, green_done, end_now;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign others = latch & ~(N_APPR'(1) << phase);
  assign phase_inc = phase == PW'(N_APPR - 1) ? '0 : phase + 1'b1;
  assign rr = next_pending(8'(latch), 3'(phase), N_APPR);
  // Past minimum green, actuated mode yields as soon as another approach waits.
  assign green_done = bus.actuated ? (dwell >= DW'(MAX_GREEN_TICKS - 1) || (dwell >= DW'(GREEN_TICKS - 1) && |others))
                                   : dwell >= DW'(GREEN_TICKS - 1);
  assign end_now = tick && (state == ST_GREEN  ? green_done :
                            state == ST_YELLOW ? dwell >= DW'(YELLOW_TICKS - 1) :
                            state == ST_ALLRED ? dwell >= DW'(CLEAR_TICKS - 1) :
                                                 dwell >= DW'(FLASH_TICKS - 1));
  always_comb begin
    state_n = state;
    phase_n = phase;
    dwell_n = dwell;
    blink_n = blink;
    first_n = first;
    latch_n = latch;
    for (int a = 0; a < N_APPR; a++)
      if (bus.req[a] && !(state == ST_GREEN && phase == PW'(a))) latch_n[a] = 1'b1;
    if (tick) dwell_n = end_now ? '0 : dwell + 1'b1;
    case (state)
      ST_GREEN: if (end_now) state_n = ST_YELLOW;
      ST_YELLOW: if (end_now) state_n = ST_ALLRED;
      ST_ALLRED:
        if (end_now) begin
          // After reset or flash the first green serves the held phase 0 instead of advancing.
          state_n = ST_GREEN;
          phase_n = first ? phase : bus.actuated ? PW'(rr) : phase_inc;
          first_n = 1'b0;
          latch_n[phase_n] = 1'b0;
        end
      ST_FLASH:
        if (!bus.flash) begin
          state_n = ST_ALLRED;
          phase_n = '0;
          first_n = 1'b1;
          dwell_n = '0;
        end else if (end_now) blink_n = !blink;
      default: begin
        state_n = ST_ALLRED;
        phase_n = '0;
        first_n = 1'b1;
        dwell_n = '0;
      end
    endcase
    if ({1'b0, phase} >= N_LIM) begin
      state_n = ST_ALLRED;
      phase_n = '0;
      first_n = 1'b1;
      dwell_n = '0;
    end
    if (bus.flash) begin
      latch_n = '0;
      if (state != ST_FLASH) begin
        state_n = ST_FLASH;
        dwell_n = '0;
        blink_n = 1'b1;
      end
    end
  end
  always_comb begin
    lamp_n = '0;
    for (int a = 0; a < N_APPR; a++)
      lamp_n[3*a +: 3] = POL ^ (state == ST_FLASH ? (blink ? LAMP_Y : LAMP_OFF) :
                                phase != PW'(a)   ? LAMP_R :
                                state == ST_GREEN ? LAMP_G :
                                state == ST_YELLOW ? LAMP_Y : LAMP_R);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_ALLRED;
      phase <= '0;
      dwell <= '0;
      latch <= '0;
      blink <= 1'b1;
      first <= 1'b1;
      bus.lamp <= {N_APPR{POL ^ LAMP_R}};
    end else begin
      state <= state_n;
      phase <= phase_n;
      dwell <= dwell_n;
      latch <= latch_n;
      blink <= blink_n;
      first <= first_n;
      bus.lamp <= lamp_n;
    end
  assign bus.phase = phase;
  assign bus.state = state;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: randomized scoreboard bench against a tick-counting reference model
module tb_traffic_intersection_ctrl;
  localparam int N = 2, TD = 4, GT = 3, MG = 6, YT = 2, CT = 1, FT = 2;
  localparam int S_G = 0, S_Y = 1, S_R = 2, S_F = 3;
  typedef struct {int st; int ph; logic [3*N-1:0] lamp;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  traffic_intersection_ctrl_if #(.N_APPR(N)) bus ();
  traffic_intersection_ctrl #(.N_APPR(N), .TICK_DIV(TD), .GREEN_TICKS(GT), .MAX_GREEN_TICKS(MG),
    .YELLOW_TICKS(YT), .CLEAR_TICKS(CT), .FLASH_TICKS(FT), .LAMP_ACTIVE_LOW(0))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  int ms, mp, mt, pc;
  bit mb, mf;
  bit pend[N];
  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask
  function automatic logic [3*N-1:0] lamp_of(input int st, input int ph, input bit bl);
    logic [3*N-1:0] l;
    for (int a = 0; a < N; a++)
      l[3*a +: 3] = st == S_F ? (bl ? 3'b010 : 3'b000) :
                    a != ph ? 3'b100 : st == S_G ? 3'b001 : st == S_Y ? 3'b010 : 3'b100;
    return l;
  endfunction
  function automatic logic [N-1:0] rnd_req(input int den);
    logic [N-1:0] r;
    for (int a = 0; a < N; a++) r[a] = $urandom_range(0, den - 1) == 0;
    return r;
  endfunction
  task automatic push(input int st, input int ph, input logic [3*N-1:0] l);
    exp_t e;
    e.st = st;
    e.ph = ph;
    e.lamp = l;
    q.push_back(e);
  endtask
  task automatic model_reset;
    ms = S_R; mp = 0; mt = 0; pc = 0; mb = 1; mf = 1;
    for (int a = 0; a < N; a++) pend[a] = 0;
  endtask
  // mt counts ticks already spent in the current state; a state ends once it reaches its duration.
  task automatic model_step(input bit f, input bit ac, input logic [N-1:0] rq);
    bit tick, waiting;
    bit np[N];
    logic [3*N-1:0] nl;
    int nx;
    tick = pc == TD - 1;
    pc = (pc + 1) % TD;
    nl = lamp_of(ms, mp, mb);
    waiting = 0;
    for (int a = 0; a < N; a++) if (a != mp && pend[a]) waiting = 1;
    for (int a = 0; a < N; a++) np[a] = pend[a] | (rq[a] && !(ms == S_G && a == mp));
    if (f) begin
      for (int a = 0; a < N; a++) np[a] = 0;
      if (ms != S_F) begin ms = S_F; mt = 0; mb = 1; end
      else if (tick) begin mt++; if (mt >= FT) begin mb = !mb; mt = 0; end end
    end else if (ms == S_F) begin
      ms = S_R; mp = 0; mf = 1; mt = 0;
    end else if (tick) begin
      mt++;
      if (ms == S_G && (ac ? (mt >= MG || (mt >= GT && waiting)) : mt >= GT)) begin ms = S_Y; mt = 0; end
      else if (ms == S_Y && mt >= YT) begin ms = S_R; mt = 0; end
      else if (ms == S_R && mt >= CT) begin
        ms = S_G; mt = 0;
        nx = (mp + 1) % N;
        for (int k = N - 1; k >= 1; k--) if (pend[(mp + k) % N]) nx = (mp + k) % N;
        if (mf) mf = 0;
        else mp = ac ? nx : (mp + 1) % N;
        np[mp] = 0;
      end
    end
    pend = np;
    push(ms, mp, nl);
  endtask
  task automatic cyc(input bit r, input bit f, input bit ac, input logic [N-1:0] rq);
    @(negedge clk);
    rst_n = r;
    bus.flash = f;
    bus.actuated = ac;
    bus.req = rq;
    if (!r) begin
      model_reset;
      push(S_R, 0, lamp_of(S_R, 0, 1));
    end else model_step(f, ac, rq);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("state", int'(bus.state), e.st);
        check("phase", int'(bus.phase), e.ph);
        check("lamp", int'(bus.lamp), int'(e.lamp));
        for (int a = 0; a < N; a++) check("one_colour", $countones(bus.lamp[3*a +: 3]) <= 1 ? 1 : 0, 1);
      end
    end
  end
  initial begin
    int n;
    bit fl, ac;
    bus.flash = 0;
    bus.actuated = 0;
    bus.req = '0;
    model_reset;
    repeat (3) cyc(0, 0, 0, '0);
    repeat (120) cyc(1, 0, 0, '0);
    repeat (100) cyc(1, 0, 1, '0);
    repeat (300) cyc(1, 0, 1, rnd_req(12));
    for (int i = 0; i < 12; i++) begin
      logic [N-1:0] held;
      held = rnd_req(2);
      repeat (16) cyc(1, 0, 1, held);
    end
    for (int i = 0; i < 4; i++) begin
      ac = 1'($urandom_range(0, 1));
      repeat ($urandom_range(5, 40)) cyc(1, 0, ac, rnd_req(6));
      repeat ($urandom_range(10, 30)) cyc(1, 1, ac, rnd_req(3));
    end
    n = 0;
    while (!(ms == S_G && mt == 1) && n < 200) begin
      cyc(1, 0, 0, '0);
      n++;
    end
    check("green_reached", n < 200 ? 1 : 0, 1);
    #2 rst_n = 0;
    #1;
    check("async_state", int'(bus.state), S_R);
    check("async_phase", int'(bus.phase), 0);
    check("async_lamp", int'(bus.lamp), int'(lamp_of(S_R, 0, 1)));
    void'(q.pop_back());
    model_reset;
    push(S_R, 0, lamp_of(S_R, 0, 1));
    repeat (2) cyc(0, 0, 0, '0);
    repeat (150) cyc(1, 0, 0, '0);
    fl = 0;
    ac = 1;
    repeat (1500) begin
      if ($urandom_range(0, 99) == 0) fl = !fl;
      if ($urandom_range(0, 79) == 0) ac = !ac;
      cyc(1, fl, ac, rnd_req(10));
    end
    @(posedge clk);
    #4;
    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
